// File: rtl/spike_accum.sv
// spike_accum: groups N signed 16-bit partial sums into one signed
// accumulator result, requantises it to a saturated signed 8-bit value and
// queues {raw sum, quantised value, saturation flag} in a 2-entry output FIFO.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   in_valid       one partial-sum beat (never back-pressured)
//   in_data        signed 16-bit partial sum
//   cfg_batch_num  beats per group (0 selects BATCH_NUM), latched per group
//   cfg_shift      rounding right-shift applied to the group sum
//   cfg_relu       clamp negative results to 0 before saturation
//   clear          abort the partial group and clear overrun
//   out_valid      FIFO head holds a result
//   out_ready      consumer accepts the head when out_valid=1
//   out_acc        raw group sum at the FIFO head
//   out_q          requantised signed 8-bit value at the FIFO head
//   out_sat        out_q was clamped
//   overrun        sticky: a finished result was dropped because the FIFO was full
//   busy           a group is in progress
module spike_accum #(
    parameter int BATCH_NUM = 1024,
    parameter int ACC_W     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [15:0]      in_data,
    input  logic [10:0]      cfg_batch_num,
    input  logic [4:0]       cfg_shift,
    input  logic             cfg_relu,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [7:0]       out_q,
    output logic             out_sat,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic {
        S_IDLE,
        S_ACCUM
    } state_t;

    localparam logic signed [ACC_W:0] Q_MAX = 127;
    localparam logic signed [ACC_W:0] Q_MIN = -128;

    // ---------------- stage 1: group accumulation ----------------
    state_t           state, state_next;
    logic [10:0]      cnt, cnt_next;
    logic [10:0]      n_lat, n_lat_next;
    logic [10:0]      n_cfg, n_eff;
    logic [ACC_W-1:0] acc, acc_next;
    logic [ACC_W-1:0] beat_x;
    logic             grp_done, grp_done_next;

    assign n_cfg  = (cfg_batch_num == 11'd0) ? 11'(BATCH_NUM) : cfg_batch_num;
    assign beat_x = {{(ACC_W-16){in_data[15]}}, in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            n_lat    <= '0;
            acc      <= '0;
            grp_done <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            n_lat    <= n_lat_next;
            acc      <= acc_next;
            grp_done <= grp_done_next;
        end
    end

    // The first beat of a group uses the live configuration; later beats use
    // the copy latched on that first beat, so mid-group changes are ignored.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        n_lat_next    = n_lat;
        acc_next      = acc;
        grp_done_next = 1'b0;
        n_eff         = (state == S_IDLE) ? n_cfg : n_lat;
        if (clear) begin
            state_next = S_IDLE;
            cnt_next   = '0;
        end else if (in_valid) begin
            if (state == S_IDLE) begin
                acc_next   = beat_x;
                n_lat_next = n_cfg;
            end else begin
                acc_next = acc + beat_x;
            end
            if (cnt == n_eff - 11'd1) begin
                cnt_next      = '0;
                state_next    = S_IDLE;
                grp_done_next = 1'b1;
            end else begin
                cnt_next   = cnt + 11'd1;
                state_next = S_ACCUM;
            end
        end
    end

    assign busy = (cnt != 11'd0);

    // ---------------- stage 2: requantisation ----------------
    // One guard bit keeps acc + rounding constant from wrapping.
    logic signed [ACC_W:0] acc_x, rnd, r_full, r_relu;
    logic [7:0]            q_val;
    logic                  sat_val;

    always_comb begin
        acc_x   = {acc[ACC_W-1], acc};
        rnd     = (cfg_shift != 5'd0) ? ((ACC_W+1)'(1) << (cfg_shift - 5'd1)) : '0;
        r_full  = (acc_x + rnd) >>> cfg_shift;
        r_relu  = (cfg_relu && r_full[ACC_W]) ? '0 : r_full;
        sat_val = 1'b0;
        if (r_relu > Q_MAX) begin
            q_val   = 8'sd127;
            sat_val = 1'b1;
        end else if (r_relu < Q_MIN) begin
            q_val   = 8'h80;
            sat_val = 1'b1;
        end else begin
            q_val = r_relu[7:0];
        end
    end

    // ---------------- 2-entry output FIFO ----------------
    logic [ACC_W-1:0] f_acc [0:1];
    logic [7:0]       f_q   [0:1];
    logic             f_sat [0:1];
    logic             wr_ptr, rd_ptr;
    logic [1:0]       count;
    logic             push, pop, full, push_ok;

    assign push    = grp_done;
    assign pop     = out_valid && out_ready;
    assign full    = (count == 2'd2);
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= ~wr_ptr;
            if (pop)     rd_ptr <= ~rd_ptr;
            if (push_ok && !pop)      count <= count + 2'd1;
            else if (!push_ok && pop) count <= count - 2'd1;
            if (clear)                        overrun <= 1'b0;
            else if (push && full && !pop)    overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            f_acc[wr_ptr] <= acc;
            f_q[wr_ptr]   <= q_val;
            f_sat[wr_ptr] <= sat_val;
        end
    end

    // Storage is not reset, so the head is masked to zero while empty.
    assign out_valid = (count != 2'd0);
    assign out_acc   = out_valid ? f_acc[rd_ptr] : '0;
    assign out_q     = out_valid ? f_q[rd_ptr]   : '0;
    assign out_sat   = out_valid ? f_sat[rd_ptr] : 1'b0;

endmodule
